sram_ctrl: RTL
==============

# sram_ctrl

Synchronous-to-asynchronous SRAM controller. It accepts single-beat read/write requests from the tinycpu core over a valid/ready interface and generates correctly sequenced active-low `cen`/`wen`/`oen` cycles for the external asynchronous SRAM. It generalises the fixed 8-bit, hand-timed access pattern to parametrised address and data width, plus programmable setup, pulse, hold and bus-turnaround cycle counts. It sits between the core's memory port and the top-level `dq` tristate pad.

## Interface
Parameters:
- `AW`, 8, address width
- `DW`, 8, data width
- `SETUP`, 1, cycles of `cen` low with address stable before the strobe (>=1)
- `PULSE`, 1, cycles `wen`/`oen` is held low (>=1)
- `HOLD`, 1, cycles of `cen` low after the strobe rises (>=1)
- `TURN`, 1, idle cycles after a read before the controller is ready again (>=0)

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller idle; request accepted when both are high
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  AW  address
- `req_wdata`  in  DW  write data
- `rsp_valid`  out  1  one-cycle pulse: read data valid
- `rsp_rdata`  out  DW  read data, held until the next read completes
- `sram_addr`  out  AW  SRAM address
- `sram_cen`, `sram_wen`, `sram_oen`  out  1 each  active-low SRAM controls
- `sram_dq_o`  out  DW  write data to the pad
- `sram_dq_oe`  out  1  pad drive enable
- `sram_dq_i`  in  DW  data from the pad

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, TURN. A shared down-counter is loaded on each phase entry with (phase length − 1).
- IDLE: `req_ready` = 1. On accept, latch `req_we`/`req_addr`/`req_wdata` and go to SETUP.
- Write path: SETUP (`cen`=0, `wen`=1, `dq_oe`=1) → PULSE (`wen`=0) → HOLD (`wen`=1, `cen`=0, `dq_oe`=1) → IDLE.
  - `dq_oe` spans all of SETUP through HOLD, so data is stable around both edges of `wen`.
  - `oen` stays 1 throughout.
  - A write produces no response.
- Read path: SETUP (`cen`=0, `oen`=1, `dq_oe`=0) → PULSE (`oen`=0) → HOLD (`oen`=1) → TURN (`cen`=1), or → IDLE directly if TURN=0.
  - `dq_oe` stays 0 for the whole read.
- Read capture:
  - `rsp_rdata` is loaded from `sram_dq_i` on the clock edge that ends the last PULSE cycle.
  - `rsp_valid` is high for exactly the following cycle, which is the first HOLD cycle.
- `sram_addr` and `sram_dq_o` are held from accept until the next accept and never change while `cen`=0.
- `req_valid` while busy is ignored. The requester holds its request until `req_ready` is high.

## Timing
- All SRAM-side outputs are registered. No combinational path runs from `req_*` to `sram_*`.
- `cen` falls on the edge that accepts the request.
- Occupancy, from the accept edge back to IDLE:
  - write: SETUP+PULSE+HOLD cycles (default 3), so back-to-back writes issue every 4 cycles;
  - read: SETUP+PULSE+HOLD+TURN cycles (default 4), so reads issue every 5 cycles.
- Read latency: `rsp_valid` rises SETUP+PULSE cycles after the accept edge (default 2).
- Reset values: state IDLE; `sram_cen`=`sram_wen`=`sram_oen`=1; `sram_dq_oe`=0; `sram_addr`=0; `sram_dq_o`=0; `rsp_valid`=0; `rsp_rdata`=0.
  - `req_ready` is 1 while in IDLE, including during reset.
- Reset mid-operation: all strobes return high and `dq_oe` drops immediately (asynchronously). The access is abandoned and no `rsp_valid` is issued.
- Read followed by write:
  - with TURN>=1, at least TURN cycles of `cen`=1 and `dq_oe`=0 separate `oen` rising from `dq_oe` rising;
  - with TURN=0, `dq_oe` rises no earlier than one cycle after `oen`.
- Counter width is `$clog2` of the maximum of the phase parameters plus 1. A counter value of 0 means "last cycle of this phase".

## Structure
- Shared package `sram_pkg` holds the state encoding (IDLE/SETUP/PULSE/HOLD/TURN localparams) and the counter-width function.
- Sub-module `sram_ctrl_timer`: loadable down-counter with a `done` output, instantiated once.
- The top-level wrapper provides the pad: `dq = sram_dq_oe ? sram_dq_o : {DW{1'bz}}`.

## Test plan
- Defaults; write 0xDE to 0xAB, then read 0xAB:
  - `cen` low 3 cycles, `wen` low exactly the middle cycle, `dq_oe` covering all 3;
  - `rsp_valid` for 1 cycle, 2 cycles after accept, with `rsp_rdata`=0xDE.
- SETUP=2, PULSE=3, HOLD=2, TURN=2; write 0xAA to 0x38, then read it back:
  - `wen` low exactly 3 cycles, write occupancy 7;
  - `rsp_valid` 5 cycles after accept, data 0xAA;
  - 2 TURN cycles with `cen`=1.
- Back-to-back requests with `req_valid` held high (writes 0x55←0xFF, 0x77←0xDD, then reads of both):
  - accepts every 4 / 5 cycles;
  - no strobe overlap between accesses;
  - readback data 0xFF, 0xDD.
- Read immediately followed by a write: `dq_oe` never high while `oen`=0; TURN gap is observed.
- Assert `rst` during PULSE of a write:
  - `wen`/`cen` go high and `dq_oe` goes low in the same cycle;
  - no `rsp_valid`;
  - after release, a read of an untouched address returns the model's content.
- `req_valid` pulsed high only while busy: request is not accepted and the SRAM is not accessed.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the asynchronous SRAM controller: FSM state
// encoding and the sizing rule for the phase down-counter.
package sram_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_TURN  = 3'd4;

  // Wide enough to hold the longest phase length; never narrower than 1 bit.
  function automatic int cnt_width(input int s, input int p, input int h, input int t);
    int m;
    m = s;
    if (p > m) m = p;
    if (h > m) m = h;
    if (t > m) m = t;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sram_ctrl_timer.sv
// Loadable phase down-counter; done flags the last cycle of the current phase.
module sram_ctrl_timer #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Single-beat valid/ready front end driving registered, correctly sequenced
// cen/wen/oen strobes for an external asynchronous SRAM.
module sram_ctrl import sram_pkg::*; #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int SETUP = 1,
  parameter int PULSE = 1,
  parameter int HOLD  = 1,
  parameter int TURN  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] sram_addr,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic          sram_oen,
  output logic [DW-1:0] sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [DW-1:0] sram_dq_i
);

  localparam int CW = cnt_width(SETUP, PULSE, HOLD, TURN);

  logic [2:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          cen_q, cen_d, wen_q, wen_d, oen_q, oen_d, dq_oe_q, dq_oe_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          load, done, accept, active;
  logic [CW-1:0] load_val;

  sram_ctrl_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  assign accept = req_valid && (state_q == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Every phase transition reloads the shared counter with (length - 1).
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    case (state_q)
      S_IDLE:  if (req_valid) begin
                 state_d = S_SETUP; load = 1'b1; load_val = CW'(SETUP - 1);
               end
      S_SETUP: if (done) begin
                 state_d = S_PULSE; load = 1'b1; load_val = CW'(PULSE - 1);
               end
      S_PULSE: if (done) begin
                 state_d = S_HOLD;  load = 1'b1; load_val = CW'(HOLD - 1);
               end
      S_HOLD:  if (done) begin
                 if (!we_q && TURN > 0) begin
                   state_d = S_TURN; load = 1'b1; load_val = CW'(TURN - 1);
                 end else begin
                   state_d = S_IDLE;
                 end
               end
      S_TURN:  if (done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are computed from the next state so they change on the same
  // edge as the state, keeping every SRAM-side output a plain flop.
  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      we_d    = req_we;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end
    active   = (state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_HOLD);
    cen_d    = !active;
    wen_d    = !((state_d == S_PULSE) && we_d);
    oen_d    = !((state_d == S_PULSE) && !we_d);
    dq_oe_d  = active && we_d;
    rvalid_d = (state_q == S_PULSE) && done && !we_q;
    rdata_d  = rvalid_d ? sram_dq_i : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cen_q    <= 1'b1;
      wen_q    <= 1'b1;
      oen_q    <= 1'b1;
      dq_oe_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cen_q    <= cen_d;
      wen_q    <= wen_d;
      oen_q    <= oen_d;
      dq_oe_q  <= dq_oe_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = rvalid_q;
  assign rsp_rdata  = rdata_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = wdata_q;
  assign sram_cen   = cen_q;
  assign sram_wen   = wen_q;
  assign sram_oen   = oen_q;
  assign sram_dq_oe = dq_oe_q;

endmodule
